// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front-end: key codes, FSM states and
// transaction-type encoding.
package atm_pkg;

    localparam logic [3:0] TECLA_ENTER    = 4'hA;
    localparam logic [3:0] TECLA_BORRAR   = 4'hB;
    localparam logic [3:0] TECLA_CANCELAR = 4'hC;
    localparam logic [3:0] TECLA_DEPOSITO = 4'hD;
    localparam logic [3:0] TECLA_RETIRO   = 4'hE;
    localparam logic [3:0] TECLA_NULA     = 4'hF;

    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

    typedef enum logic [2:0] {
        ST_INACTIVO = 3'd0,
        ST_PIN      = 3'd1,
        ST_TIPO     = 3'd2,
        ST_MONTO    = 3'd3,
        ST_ESPERA   = 3'd4,
        ST_BLOQUEO  = 3'd5
    } estado_t;

    function automatic logic es_digito(input logic [3:0] tecla);
        return (tecla <= 4'd9);
    endfunction

endpackage

// File: rtl/atm_detector_flanco.sv
// Registered rising-edge detector. The previous-value register resets to 1 so
// a level that is already high when reset is released is not seen as an edge.
module atm_detector_flanco (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_senal,
    output logic o_flanco
);

    logic r_previo;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_previo <= 1'b1;
        end else begin
            r_previo <= i_senal;
        end
    end

    assign o_flanco = i_senal & ~r_previo;

endmodule

// File: rtl/atm_teclado.sv
// Keypad front-end for the ATM controller: turns key edges into PIN digit
// strobes, a transaction type and a committed binary amount.
module atm_teclado
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS   = 4,
    parameter int MONTO_DIGITS = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_tecla,
    input  logic        i_tecla_valida,
    input  logic        i_tarjeta_recibida,
    input  logic        i_pin_incorrecto,
    input  logic        i_bloqueo,
    input  logic        i_balance_actualizado,
    input  logic        i_entregar_dinero,
    input  logic        i_fondos_insuficientes,
    output logic [3:0]  o_digito,
    output logic        o_digito_stb,
    output logic        o_tipo_trans,
    output logic [31:0] o_monto,
    output logic        o_monto_stb,
    output logic        o_error_tecla
);

    localparam int PW = $clog2(PIN_DIGITS + 1);
    localparam int MW = $clog2(MONTO_DIGITS + 1);
    localparam logic [PW-1:0] PIN_MAX   = PW'(PIN_DIGITS);
    localparam logic [MW-1:0] MONTO_MAX = MW'(MONTO_DIGITS);

    estado_t       r_estado, w_estado;
    logic [3:0]    r_digito, w_digito;
    logic          r_digito_stb, w_digito_stb;
    logic          r_tipo, w_tipo;
    logic [31:0]   r_monto, w_monto;
    logic          r_monto_stb, w_monto_stb;
    logic          r_error, w_error;
    logic [31:0]   r_acc, w_acc;
    logic [PW-1:0] r_cnt_pin, w_cnt_pin;
    logic [MW-1:0] r_cnt_monto, w_cnt_monto;

    logic          w_flanco_tecla;
    logic          w_flanco_tarjeta;
    logic          w_es_digito;
    logic          w_resultado;
    logic [PW-1:0] w_cnt_pin_inc;

    atm_detector_flanco u_flanco_tecla (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_senal  (i_tecla_valida),
        .o_flanco (w_flanco_tecla)
    );

    atm_detector_flanco u_flanco_tarjeta (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_senal  (i_tarjeta_recibida),
        .o_flanco (w_flanco_tarjeta)
    );

    assign w_es_digito   = es_digito(i_tecla);
    assign w_resultado   = i_balance_actualizado | i_entregar_dinero | i_fondos_insuficientes;
    assign w_cnt_pin_inc = r_cnt_pin + PW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_estado     <= ST_INACTIVO;
            r_digito     <= '0;
            r_digito_stb <= 1'b0;
            r_tipo       <= TIPO_DEPOSITO;
            r_monto      <= '0;
            r_monto_stb  <= 1'b0;
            r_error      <= 1'b0;
            r_acc        <= '0;
            r_cnt_pin    <= '0;
            r_cnt_monto  <= '0;
        end else begin
            r_estado     <= w_estado;
            r_digito     <= w_digito;
            r_digito_stb <= w_digito_stb;
            r_tipo       <= w_tipo;
            r_monto      <= w_monto;
            r_monto_stb  <= w_monto_stb;
            r_error      <= w_error;
            r_acc        <= w_acc;
            r_cnt_pin    <= w_cnt_pin;
            r_cnt_monto  <= w_cnt_monto;
        end
    end

    // Controller events outrank keys; a key edge in the same cycle is consumed silently.
    always_comb begin
        w_estado     = r_estado;
        w_digito     = r_digito;
        w_digito_stb = 1'b0;
        w_tipo       = r_tipo;
        w_monto      = r_monto;
        w_monto_stb  = 1'b0;
        w_error      = 1'b0;
        w_acc        = r_acc;
        w_cnt_pin    = r_cnt_pin;
        w_cnt_monto  = r_cnt_monto;

        if (i_bloqueo && (r_estado != ST_INACTIVO)) begin
            w_estado = ST_BLOQUEO;
        end else if (i_pin_incorrecto &&
                     ((r_estado == ST_TIPO) || (r_estado == ST_MONTO) || (r_estado == ST_ESPERA))) begin
            w_estado    = ST_PIN;
            w_cnt_pin   = '0;
            w_acc       = '0;
            w_cnt_monto = '0;
        end else begin
            case (r_estado)
                ST_INACTIVO: begin
                    if (w_flanco_tarjeta) begin
                        w_estado    = ST_PIN;
                        w_cnt_pin   = '0;
                        w_acc       = '0;
                        w_cnt_monto = '0;
                    end
                end
                ST_PIN: begin
                    if (w_flanco_tecla) begin
                        if (w_es_digito) begin
                            w_digito     = i_tecla;
                            w_digito_stb = 1'b1;
                            w_cnt_pin    = w_cnt_pin_inc;
                            if (w_cnt_pin_inc == PIN_MAX) begin
                                w_estado = ST_TIPO;
                            end
                        end else if (i_tecla == TECLA_CANCELAR) begin
                            w_estado = ST_INACTIVO;
                        end else if (i_tecla != TECLA_NULA) begin
                            w_error = 1'b1;
                        end
                    end
                end
                ST_TIPO: begin
                    if (w_flanco_tecla) begin
                        if (i_tecla == TECLA_DEPOSITO) begin
                            w_tipo   = TIPO_DEPOSITO;
                            w_estado = ST_MONTO;
                        end else if (i_tecla == TECLA_RETIRO) begin
                            w_tipo   = TIPO_RETIRO;
                            w_estado = ST_MONTO;
                        end else if (i_tecla == TECLA_CANCELAR) begin
                            w_estado = ST_INACTIVO;
                        end else if (i_tecla != TECLA_NULA) begin
                            w_error = 1'b1;
                        end
                    end
                end
                ST_MONTO: begin
                    if (w_flanco_tecla) begin
                        if (w_es_digito) begin
                            if (r_cnt_monto == MONTO_MAX) begin
                                w_error = 1'b1;
                            end else begin
                                w_acc       = (r_acc << 3) + (r_acc << 1) + {28'd0, i_tecla};
                                w_cnt_monto = r_cnt_monto + MW'(1);
                            end
                        end else if (i_tecla == TECLA_BORRAR) begin
                            w_acc       = '0;
                            w_cnt_monto = '0;
                        end else if (i_tecla == TECLA_ENTER) begin
                            if (r_cnt_monto != '0) begin
                                w_monto     = r_acc;
                                w_monto_stb = 1'b1;
                                w_estado    = ST_ESPERA;
                            end else begin
                                w_error = 1'b1;
                            end
                        end else if (i_tecla == TECLA_CANCELAR) begin
                            w_estado = ST_INACTIVO;
                        end else if (i_tecla != TECLA_NULA) begin
                            w_error = 1'b1;
                        end
                    end
                end
                ST_ESPERA: begin
                    if (w_resultado) begin
                        w_estado = ST_INACTIVO;
                    end
                end
                ST_BLOQUEO: begin
                    w_estado = ST_BLOQUEO;
                end
                default: begin
                    w_estado = ST_INACTIVO;
                end
            endcase
        end
    end

    assign o_digito      = r_digito;
    assign o_digito_stb  = r_digito_stb;
    assign o_tipo_trans  = r_tipo;
    assign o_monto       = r_monto;
    assign o_monto_stb   = r_monto_stb;
    assign o_error_tecla = r_error;

endmodule
